pipelined_barrel_shifter: RTL and testbench

PIPELINED_BARREL_SHIFTER -- requirements
Module: pipelined_barrel_shifter

---
 rtl/pipelined_barrel_shifter_pkg.sv | 18 +
 rtl/pipelined_barrel_shifter_shift_stage.sv | 37 +++
 rtl/pipelined_barrel_shifter.sv | 131 +++++++++++++
 tb/tb_pipelined_barrel_shifter.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipelined_barrel_shifter_pkg.sv
// Shared constants for the two-stage pipelined barrel shifter.
package pipelined_barrel_shifter_pkg;

  localparam int unsigned MODE_BITS = 2;

  typedef enum logic [MODE_BITS-1:0] {
    MODE_SLL = 2'd0,
    MODE_SRL = 2'd1,
    MODE_SRA = 2'd2,
    MODE_ROR = 2'd3
  } shift_mode_e;

  // Low-order amount bits handled by the first stage (the larger half).
  function automatic int unsigned lo_bits(input int unsigned shift_bits);
    return shift_bits - (shift_bits / 2);
  endfunction

endpackage

// File: rtl/pipelined_barrel_shifter_shift_stage.sv
// Combinational partial shifter: moves data by sel_i * STEP positions in the selected mode.
module shift_stage
  import pipelined_barrel_shifter_pkg::*;
#(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned STEP     = 1,
  parameter int unsigned SEL_BITS = 3
) (
  input  logic [WIDTH-1:0]     data_i,
  input  logic [SEL_BITS-1:0]  sel_i,
  input  logic [MODE_BITS-1:0] mode_i,
  input  logic                 fill_i,
  output logic [WIDTH-1:0]     shifted_o
);

  localparam int unsigned DIST_BITS = $clog2(2 * WIDTH);

  logic [DIST_BITS-1:0] dist_c;
  logic [DIST_BITS-1:0] wrap_c;
  logic [WIDTH-1:0]     fill_mask_c;

  // A zero distance makes wrap_c equal WIDTH, so the rotate's left term vanishes.
  always_comb begin
    dist_c      = DIST_BITS'(sel_i) * DIST_BITS'(STEP);
    wrap_c      = DIST_BITS'(WIDTH) - dist_c;
    fill_mask_c = fill_i ? ~({WIDTH{1'b1}} >> dist_c) : '0;
    shifted_o   = data_i;
    case (mode_i)
      MODE_SLL: shifted_o = data_i << dist_c;
      MODE_SRL: shifted_o = data_i >> dist_c;
      MODE_SRA: shifted_o = (data_i >> dist_c) | fill_mask_c;
      MODE_ROR: shifted_o = (data_i >> dist_c) | (data_i << wrap_c);
      default:  shifted_o = data_i;
    endcase
  end

endmodule

// File: rtl/pipelined_barrel_shifter.sv
// Two-stage barrel shifter (SLL/SRL/SRA/ROR) with valid/ready flow control and a tag sideband.
module pipelined_barrel_shifter
  import pipelined_barrel_shifter_pkg::*;
#(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned TAG_WIDTH = 4,
  localparam int unsigned SHIFT_BITS = $clog2(WIDTH),
  localparam int unsigned LO_BITS    = lo_bits(SHIFT_BITS),
  localparam int unsigned HI_BITS    = SHIFT_BITS / 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      in_data,
  input  logic [SHIFT_BITS-1:0] in_amount,
  input  logic [1:0]            in_mode,
  input  logic [TAG_WIDTH-1:0]  in_tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic [TAG_WIDTH-1:0]  out_tag
);

  // Stage 1 registers: partially shifted data plus everything stage 2 still needs.
  logic                 s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0]     s1_data_q, s1_data_d;
  logic [HI_BITS-1:0]   s1_hi_q, s1_hi_d;
  logic [MODE_BITS-1:0] s1_mode_q, s1_mode_d;
  logic [TAG_WIDTH-1:0] s1_tag_q, s1_tag_d;
  logic                 s1_msb_q, s1_msb_d;

  // Stage 2 registers drive the outputs directly.
  logic                 s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0]     s2_data_q, s2_data_d;
  logic [TAG_WIDTH-1:0] s2_tag_q, s2_tag_d;

  logic                 s1_adv_c;
  logic                 s2_adv_c;
  logic [WIDTH-1:0]     s1_shift_c;
  logic [WIDTH-1:0]     s2_shift_c;

  assign s2_adv_c = !s2_valid_q || out_ready;
  assign s1_adv_c = !s1_valid_q || s2_adv_c;
  assign in_ready = reset || s1_adv_c;

  assign out_valid = s2_valid_q;
  assign out_data  = s2_data_q;
  assign out_tag   = s2_tag_q;

  shift_stage #(
    .WIDTH    (WIDTH),
    .STEP     (1),
    .SEL_BITS (LO_BITS)
  ) u_stage_lo (
    .data_i    (in_data),
    .sel_i     (in_amount[LO_BITS-1:0]),
    .mode_i    (in_mode),
    .fill_i    (in_data[WIDTH-1]),
    .shifted_o (s1_shift_c)
  );

  // Stage 2 fills arithmetic shifts from the operand's original sign bit.
  shift_stage #(
    .WIDTH    (WIDTH),
    .STEP     (1 << LO_BITS),
    .SEL_BITS (HI_BITS)
  ) u_stage_hi (
    .data_i    (s1_data_q),
    .sel_i     (s1_hi_q),
    .mode_i    (s1_mode_q),
    .fill_i    (s1_msb_q),
    .shifted_o (s2_shift_c)
  );

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_data_d  = s1_data_q;
    s1_hi_d    = s1_hi_q;
    s1_mode_d  = s1_mode_q;
    s1_tag_d   = s1_tag_q;
    s1_msb_d   = s1_msb_q;
    s2_valid_d = s2_valid_q;
    s2_data_d  = s2_data_q;
    s2_tag_d   = s2_tag_q;

    if (s1_adv_c) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_data_d = s1_shift_c;
        s1_hi_d   = in_amount[SHIFT_BITS-1:LO_BITS];
        s1_mode_d = in_mode;
        s1_tag_d  = in_tag;
        s1_msb_d  = in_data[WIDTH-1];
      end
    end

    if (s2_adv_c) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_data_d = s2_shift_c;
        s2_tag_d  = s1_tag_q;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_hi_q    <= '0;
      s1_mode_q  <= '0;
      s1_tag_q   <= '0;
      s1_msb_q   <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      s2_tag_q   <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
      s1_hi_q    <= s1_hi_d;
      s1_mode_q  <= s1_mode_d;
      s1_tag_q   <= s1_tag_d;
      s1_msb_q   <= s1_msb_d;
      s2_valid_q <= s2_valid_d;
      s2_data_q  <= s2_data_d;
      s2_tag_q   <= s2_tag_d;
    end
  end

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Bench for pipelined_barrel_shifter: directed 32-bit cases plus 8/64-bit random sweeps against a scoreboard.
module tb_pipelined_barrel_shifter;
  import pipelined_barrel_shifter_pkg::*;

  localparam int unsigned TW   = 4;
  localparam int unsigned NOPS = 10000;

  typedef struct packed {
    logic [63:0]   data;
    logic [TW-1:0] tag;
  } exp_t;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  exp_t          sb[3][$];
  logic [TW-1:0] ret32[$];
  logic          done8  = 1'b0;
  logic          done64 = 1'b0;

  // WIDTH=32 instance
  logic          rst32 = 1'b1, iv32 = 1'b0, ir32, ov32, or32 = 1'b1;
  logic [31:0]   id32 = '0, od32;
  logic [4:0]    ia32 = '0;
  logic [1:0]    im32 = '0;
  logic [TW-1:0] it32 = '0, ot32;

  // WIDTH=8 instance
  logic          rst8 = 1'b1, iv8 = 1'b0, ir8, ov8, or8 = 1'b1;
  logic [7:0]    id8 = '0, od8;
  logic [2:0]    ia8 = '0;
  logic [1:0]    im8 = '0;
  logic [TW-1:0] it8 = '0, ot8;

  // WIDTH=64 instance
  logic          rst64 = 1'b1, iv64 = 1'b0, ir64, ov64, or64 = 1'b1;
  logic [63:0]   id64 = '0, od64;
  logic [5:0]    ia64 = '0;
  logic [1:0]    im64 = '0;
  logic [TW-1:0] it64 = '0, ot64;

  pipelined_barrel_shifter #(.WIDTH(32), .TAG_WIDTH(TW)) dut32 (
    .clock(clock), .reset(rst32), .in_valid(iv32), .in_ready(ir32), .in_data(id32),
    .in_amount(ia32), .in_mode(im32), .in_tag(it32), .out_valid(ov32),
    .out_ready(or32), .out_data(od32), .out_tag(ot32));

  pipelined_barrel_shifter #(.WIDTH(8), .TAG_WIDTH(TW)) dut8 (
    .clock(clock), .reset(rst8), .in_valid(iv8), .in_ready(ir8), .in_data(id8),
    .in_amount(ia8), .in_mode(im8), .in_tag(it8), .out_valid(ov8),
    .out_ready(or8), .out_data(od8), .out_tag(ot8));

  pipelined_barrel_shifter #(.WIDTH(64), .TAG_WIDTH(TW)) dut64 (
    .clock(clock), .reset(rst64), .in_valid(iv64), .in_ready(ir64), .in_data(id64),
    .in_amount(ia64), .in_mode(im64), .in_tag(it64), .out_valid(ov64),
    .out_ready(or64), .out_data(od64), .out_tag(ot64));

  // Reference shift computed from the operation definitions with plain arithmetic.
  function automatic logic [63:0] model(input int unsigned w, input logic [63:0] d,
                                        input int unsigned a, input logic [1:0] m);
    logic [63:0] mask;
    logic [63:0] x;
    mask = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    x    = d & mask;
    case (m)
      2'd0:    return (x << a) & mask;
      2'd1:    return x >> a;
      2'd2:    return x[w-1] ? ((x >> a) | (mask & ~(mask >> a))) : (x >> a);
      default: return ((x >> a) | (x << (w - a))) & mask;
    endcase
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One cycle of scoreboard bookkeeping for one instance, sampled mid-cycle.
  task automatic mon(input int id, input int unsigned w, input logic rst, input logic iv,
                     input logic ir, input logic [63:0] din, input int unsigned amt,
                     input logic [1:0] md, input logic [TW-1:0] tin, input logic ov,
                     input logic ordy, input logic [63:0] dout, input logic [TW-1:0] tout);
    exp_t e;
    chk($sformatf("in_ready_w%0d", w), 64'(ir), 64'(rst || sb[id].size() < 2 || ordy));
    if (ov === 1'b1) begin
      if (sb[id].size() == 0) begin
        checks++;
        failures++;
        $display("FAIL spurious_out_w%0d: got result 0x%0h expected no result", w, dout);
      end else begin
        e = sb[id][0];
        chk($sformatf("out_data_w%0d", w), dout, e.data);
        chk($sformatf("out_tag_w%0d", w), 64'(tout), 64'(e.tag));
        if (ordy && !rst) begin
          void'(sb[id].pop_front());
          if (id == 0) ret32.push_back(tout);
        end
      end
    end
    if (rst) begin
      sb[id].delete();
    end else if (iv && ir) begin
      e.data = model(w, din, amt, md);
      e.tag  = tin;
      sb[id].push_back(e);
    end
  endtask

  always @(negedge clock) begin
    mon(0, 32, rst32, iv32, ir32, 64'(id32), 32'(ia32), im32, it32, ov32, or32, 64'(od32), ot32);
    mon(1, 8, rst8, iv8, ir8, 64'(id8), 32'(ia8), im8, it8, ov8, or8, 64'(od8), ot8);
    mon(2, 64, rst64, iv64, ir64, id64, 32'(ia64), im64, it64, ov64, or64, od64, ot64);
  end

  // Single op on the idle 32-bit pipe; checks exact two-cycle latency against a literal.
  task automatic op32(input string name, input logic [31:0] d, input logic [4:0] a,
                      input logic [1:0] m, input logic [TW-1:0] t, input logic [31:0] exp);
    iv32 = 1'b1; id32 = d; ia32 = a; im32 = m; it32 = t;
    @(posedge clock); #1;
    iv32 = 1'b0;
    chk({name, "_valid_n1"}, 64'(ov32), 64'd0);
    @(posedge clock); #1;
    chk({name, "_valid_n2"}, 64'(ov32), 64'd1);
    chk({name, "_data"}, 64'(od32), 64'(exp));
    chk({name, "_tag"}, 64'(ot32), 64'(t));
    @(posedge clock); #1;
  endtask

  initial begin : directed
    logic acc;
    int   lows;
    int   guard;
    repeat (2) @(posedge clock);
    #1;
    chk("reset_out_valid", 64'(ov32), 64'd0);
    chk("reset_out_data", 64'(od32), 64'd0);
    chk("reset_out_tag", 64'(ot32), 64'd0);
    chk("reset_in_ready", 64'(ir32), 64'd1);
    rst32 = 1'b0;
    @(posedge clock); #1;

    op32("sll31", 32'h0000_0001, 5'd31, MODE_SLL, 4'h5, 32'h8000_0000);
    op32("sra4", 32'h8000_0010, 5'd4, MODE_SRA, 4'h6, 32'hF800_0001);
    op32("srl4", 32'h8000_0010, 5'd4, MODE_SRL, 4'h7, 32'h0800_0001);
    op32("ror4", 32'h0000_00F1, 5'd4, MODE_ROR, 4'h8, 32'h1000_000F);
    op32("zero_sll", 32'hDEAD_BEEF, 5'd0, MODE_SLL, 4'h1, 32'hDEAD_BEEF);
    op32("zero_srl", 32'hDEAD_BEEF, 5'd0, MODE_SRL, 4'h2, 32'hDEAD_BEEF);
    op32("zero_sra", 32'hDEAD_BEEF, 5'd0, MODE_SRA, 4'h3, 32'hDEAD_BEEF);
    op32("zero_ror", 32'hDEAD_BEEF, 5'd0, MODE_ROR, 4'h4, 32'hDEAD_BEEF);

    // Eight back-to-back ops with the consumer stalled for four cycles.
    ret32.delete();
    lows = 0;
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          iv32 = 1'b1;
          id32 = 32'h0101_0101 * 32'(i + 1);
          ia32 = 5'(i * 5);
          im32 = 2'(i);
          it32 = 4'(i);
          guard = 0;
          do begin
            @(negedge clock);
            acc = ir32;
            if (!acc) lows++;
            @(posedge clock); #1;
            guard++;
          end while (!acc && guard < 50);
          chk("stall_accept", 64'(acc), 64'd1);
        end
        iv32 = 1'b0;
      end
      begin
        for (int c = 0; c < 12; c++) begin
          or32 = !(c >= 3 && c <= 6);
          @(posedge clock); #1;
        end
        or32 = 1'b1;
      end
    join
    for (int g = 0; g < 100 && sb[0].size() != 0; g++) @(posedge clock);
    #1;
    chk("stall_in_ready_low", 64'(lows > 0), 64'd1);
    chk("stall_drained", 64'(sb[0].size()), 64'd0);
    chk("stall_count", 64'(ret32.size()), 64'd8);
    for (int i = 0; i < ret32.size(); i++) chk($sformatf("stall_order_%0d", i), 64'(ret32[i]), 64'(i));

    // Reset while both stages hold operations.
    or32 = 1'b0;
    iv32 = 1'b1; id32 = 32'h1234_5678; ia32 = 5'd3; im32 = MODE_SLL; it32 = 4'hA;
    @(posedge clock); #1;
    id32 = 32'h8765_4321; ia32 = 5'd9; im32 = MODE_SRA; it32 = 4'hB;
    @(posedge clock); #1;
    iv32 = 1'b0;
    chk("pre_reset_out_valid", 64'(ov32), 64'd1);
    chk("pre_reset_in_ready", 64'(ir32), 64'd0);
    rst32 = 1'b1;
    iv32 = 1'b1; id32 = 32'hFFFF_FFFF; ia32 = 5'd1; im32 = MODE_SRL; it32 = 4'hC;
    @(posedge clock); #1;
    chk("midreset_out_valid", 64'(ov32), 64'd0);
    chk("midreset_out_data", 64'(od32), 64'd0);
    chk("midreset_out_tag", 64'(ot32), 64'd0);
    rst32 = 1'b0;
    iv32 = 1'b0;
    or32 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clock); #1;
      chk("post_reset_no_stale", 64'(ov32), 64'd0);
    end

    for (int g = 0; g < 100000 && !(done8 && done64); g++) @(posedge clock);
    chk("sweeps_done", 64'(done8 && done64), 64'd1);
    for (int g = 0; g < 200 && (sb[1].size() != 0 || sb[2].size() != 0); g++) @(posedge clock);
    #1;
    chk("sweep8_drained", 64'(sb[1].size()), 64'd0);
    chk("sweep64_drained", 64'(sb[2].size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : ready_noise
    forever begin
      @(posedge clock); #1;
      or8  = 1'($urandom_range(1));
      or64 = 1'($urandom_range(1));
    end
  end

  initial begin : sweep8
    logic acc;
    int   guard;
    repeat (3) @(posedge clock);
    #1;
    rst8 = 1'b0;
    for (int n = 0; n < NOPS; ) begin
      if ($urandom_range(3) != 0) begin
        iv8 = 1'b1; id8 = 8'($urandom); ia8 = 3'($urandom); im8 = 2'($urandom); it8 = 4'($urandom);
        guard = 0;
        do begin
          @(negedge clock);
          acc = ir8;
          @(posedge clock); #1;
          guard++;
        end while (!acc && guard < 100);
        if (!acc) chk("sweep8_accept", 64'(acc), 64'd1);
        n++;
      end else begin
        iv8 = 1'b0;
        @(posedge clock); #1;
      end
    end
    iv8 = 1'b0;
    done8 = 1'b1;
  end

  initial begin : sweep64
    logic acc;
    int   guard;
    repeat (3) @(posedge clock);
    #1;
    rst64 = 1'b0;
    for (int n = 0; n < NOPS; ) begin
      if ($urandom_range(3) != 0) begin
        iv64 = 1'b1; id64 = {$urandom, $urandom}; ia64 = 6'($urandom);
        im64 = 2'($urandom); it64 = 4'($urandom);
        guard = 0;
        do begin
          @(negedge clock);
          acc = ir64;
          @(posedge clock); #1;
          guard++;
        end while (!acc && guard < 100);
        if (!acc) chk("sweep64_accept", 64'(acc), 64'd1);
        n++;
      end else begin
        iv64 = 1'b0;
        @(posedge clock); #1;
      end
    end
    iv64 = 1'b0;
    done64 = 1'b1;
  end

  initial begin : watchdog
    #3_000_000;
    $display("FAIL watchdog: got timeout expected completion (checks=%0d failures=%0d)", checks, failures);
    $fatal(1, "simulation time limit reached");
  end

endmodule
